stride_window_sequencer: RTL and testbench

- Scheduler for the convolution window scan over one input feature map.
- Steps the window origin (row, col) by a configurable stride across the map.
- Hands each window position to the convolution datapath over a valid/ready handshake.
- Issues registered, glitch-free one-cycle clear pulses for the downstream stride/equal-stride counters. These pulses replace level/clock-derived clears.

---
 rtl/stride_window_sequencer.sv | 145 ++++++++++++++
 tb/tb_stride_window_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/stride_window_sequencer.sv
// Convolution window-origin scheduler: walks (row, col) by stride S across a W x H map and
// issues one-cycle registered clears to the stride counters. Optional window counter under
// STRIDE_WINDOW_SEQUENCER_WINCOUNT_EN.
module stride_window_sequencer #(
  parameter int DIM_W = 8,
  parameter int KER_W = 4
) (
  input  logic             STRIDE_WINDOW_SEQUENCER_Clk,
  input  logic             STRIDE_WINDOW_SEQUENCER_Reset_InLow,
  input  logic             STRIDE_WINDOW_SEQUENCER_Start,
  input  logic [DIM_W-1:0] STRIDE_WINDOW_SEQUENCER_Img_Width,
  input  logic [DIM_W-1:0] STRIDE_WINDOW_SEQUENCER_Img_Height,
  input  logic [KER_W-1:0] STRIDE_WINDOW_SEQUENCER_Kernel_Size,
  input  logic [KER_W-1:0] STRIDE_WINDOW_SEQUENCER_Stride,
  input  logic             STRIDE_WINDOW_SEQUENCER_Win_Ready,
  output logic             STRIDE_WINDOW_SEQUENCER_Win_Valid,
  output logic [DIM_W-1:0] STRIDE_WINDOW_SEQUENCER_Win_Row,
  output logic [DIM_W-1:0] STRIDE_WINDOW_SEQUENCER_Win_Col,
  output logic             STRIDE_WINDOW_SEQUENCER_Counter_Eqst_Clr,
  output logic             STRIDE_WINDOW_SEQUENCER_Row_Clr,
  output logic             STRIDE_WINDOW_SEQUENCER_Busy,
  output logic             STRIDE_WINDOW_SEQUENCER_Done,
  output logic             STRIDE_WINDOW_SEQUENCER_Error
`ifdef STRIDE_WINDOW_SEQUENCER_WINCOUNT_EN
  ,
  output logic [2*DIM_W-1:0] STRIDE_WINDOW_SEQUENCER_Win_Count
`endif
);

  localparam int PAD_W = DIM_W + 1 - KER_W;
  localparam int PAD_D = DIM_W - KER_W;

  typedef enum logic [1:0] {IDLE, CHECK, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [DIM_W-1:0] w_q, h_q, row_q, col_q;
  logic [KER_W-1:0] k_q, s_q;
  logic             valid_q, eqst_clr_q, row_clr_q, busy_q, done_q, error_q;

  logic [DIM_W:0]   k_ext, s_ext, col_end, row_end;
  logic             cfg_ok, accept, col_step, row_step, last;

  // Bound checks carry one extra bit so col+S+K cannot wrap.
  assign k_ext   = {{PAD_W{1'b0}}, k_q};
  assign s_ext   = {{PAD_W{1'b0}}, s_q};
  assign col_end = {1'b0, col_q} + s_ext + k_ext;
  assign row_end = {1'b0, row_q} + s_ext + k_ext;
  assign cfg_ok  = (k_q != '0) && (s_q != '0) &&
                   (k_ext <= {1'b0, w_q}) && (k_ext <= {1'b0, h_q});
  assign accept  = valid_q & STRIDE_WINDOW_SEQUENCER_Win_Ready;

  always_ff @(posedge STRIDE_WINDOW_SEQUENCER_Clk or negedge STRIDE_WINDOW_SEQUENCER_Reset_InLow) begin
    if (!STRIDE_WINDOW_SEQUENCER_Reset_InLow) state_q <= IDLE;
    else                                      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    col_step = 1'b0;
    row_step = 1'b0;
    last     = 1'b0;
    case (state_q)
      IDLE:  if (STRIDE_WINDOW_SEQUENCER_Start) state_d = CHECK;
      CHECK: state_d = cfg_ok ? RUN : DONE;
      RUN: begin
        if (accept) begin
          if (col_end <= {1'b0, w_q})      col_step = 1'b1;
          else if (row_end <= {1'b0, h_q}) row_step = 1'b1;
          else begin
            last    = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge STRIDE_WINDOW_SEQUENCER_Clk or negedge STRIDE_WINDOW_SEQUENCER_Reset_InLow) begin
    if (!STRIDE_WINDOW_SEQUENCER_Reset_InLow) begin
      w_q        <= '0;
      h_q        <= '0;
      k_q        <= '0;
      s_q        <= '0;
      row_q      <= '0;
      col_q      <= '0;
      valid_q    <= 1'b0;
      eqst_clr_q <= 1'b0;
      row_clr_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      eqst_clr_q <= col_step | row_step;
      row_clr_q  <= row_step;
      busy_q     <= (state_d == CHECK) || (state_d == RUN);
      done_q     <= ((state_q == CHECK) && !cfg_ok) || last;
      if ((state_q == IDLE) && STRIDE_WINDOW_SEQUENCER_Start) begin
        w_q     <= STRIDE_WINDOW_SEQUENCER_Img_Width;
        h_q     <= STRIDE_WINDOW_SEQUENCER_Img_Height;
        k_q     <= STRIDE_WINDOW_SEQUENCER_Kernel_Size;
        s_q     <= STRIDE_WINDOW_SEQUENCER_Stride;
        error_q <= 1'b0;
      end
      if (state_q == CHECK) begin
        if (cfg_ok) begin
          row_q   <= '0;
          col_q   <= '0;
          valid_q <= 1'b1;
        end else begin
          error_q <= 1'b1;
        end
      end
      if (col_step) col_q <= col_q + {{PAD_D{1'b0}}, s_q};
      if (row_step) begin
        col_q <= '0;
        row_q <= row_q + {{PAD_D{1'b0}}, s_q};
      end
      if (last) valid_q <= 1'b0;
    end
  end

`ifdef STRIDE_WINDOW_SEQUENCER_WINCOUNT_EN
  logic [2*DIM_W-1:0] win_count_q;

  always_ff @(posedge STRIDE_WINDOW_SEQUENCER_Clk or negedge STRIDE_WINDOW_SEQUENCER_Reset_InLow) begin
    if (!STRIDE_WINDOW_SEQUENCER_Reset_InLow)                    win_count_q <= '0;
    else if ((state_q == IDLE) && STRIDE_WINDOW_SEQUENCER_Start) win_count_q <= '0;
    else if (accept)                                             win_count_q <= win_count_q + 1'b1;
  end

  assign STRIDE_WINDOW_SEQUENCER_Win_Count = win_count_q;
`endif

  assign STRIDE_WINDOW_SEQUENCER_Win_Valid        = valid_q;
  assign STRIDE_WINDOW_SEQUENCER_Win_Row          = row_q;
  assign STRIDE_WINDOW_SEQUENCER_Win_Col          = col_q;
  assign STRIDE_WINDOW_SEQUENCER_Counter_Eqst_Clr = eqst_clr_q;
  assign STRIDE_WINDOW_SEQUENCER_Row_Clr          = row_clr_q;
  assign STRIDE_WINDOW_SEQUENCER_Busy             = busy_q;
  assign STRIDE_WINDOW_SEQUENCER_Done             = done_q;
  assign STRIDE_WINDOW_SEQUENCER_Error            = error_q;

endmodule

// File: tb/tb_stride_window_sequencer.sv
// Directed bench for stride_window_sequencer: scan order, latency, clears, backpressure,
// illegal config, ignored restart and mid-scan reset.
module tb_stride_window_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] img_w = '0, img_h = '0;
  logic [3:0] ker = '0, stride = '0;
  logic       ready = 1'b1;
  logic       win_valid, eqst_clr, row_clr, busy, done, error;
  logic [7:0] win_row, win_col;
`ifdef STRIDE_WINDOW_SEQUENCER_WINCOUNT_EN
  logic [15:0] win_count;
`endif

  int checks = 0;
  int errors = 0;

  int exp_r[$];
  int exp_c[$];
  int stall_r = -1, stall_c = -1, stall_len = 0;
  int poke_cyc = -1;

  always #5 clk = ~clk;

  stride_window_sequencer #(.DIM_W(8), .KER_W(4)) dut (
    .STRIDE_WINDOW_SEQUENCER_Clk              (clk),
    .STRIDE_WINDOW_SEQUENCER_Reset_InLow      (rst_n),
    .STRIDE_WINDOW_SEQUENCER_Start            (start),
    .STRIDE_WINDOW_SEQUENCER_Img_Width        (img_w),
    .STRIDE_WINDOW_SEQUENCER_Img_Height       (img_h),
    .STRIDE_WINDOW_SEQUENCER_Kernel_Size      (ker),
    .STRIDE_WINDOW_SEQUENCER_Stride           (stride),
    .STRIDE_WINDOW_SEQUENCER_Win_Ready        (ready),
    .STRIDE_WINDOW_SEQUENCER_Win_Valid        (win_valid),
    .STRIDE_WINDOW_SEQUENCER_Win_Row          (win_row),
    .STRIDE_WINDOW_SEQUENCER_Win_Col          (win_col),
    .STRIDE_WINDOW_SEQUENCER_Counter_Eqst_Clr (eqst_clr),
    .STRIDE_WINDOW_SEQUENCER_Row_Clr          (row_clr),
    .STRIDE_WINDOW_SEQUENCER_Busy             (busy),
    .STRIDE_WINDOW_SEQUENCER_Done             (done),
    .STRIDE_WINDOW_SEQUENCER_Error            (error)
`ifdef STRIDE_WINDOW_SEQUENCER_WINCOUNT_EN
    ,
    .STRIDE_WINDOW_SEQUENCER_Win_Count        (win_count)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_outs"}, {24'd0, win_valid, eqst_clr, row_clr, busy, done, error, 2'd0}, 32'd0);
    check_eq({tag, "_rowcol"}, {16'd0, win_row, win_col}, 32'd0);
  endtask

  task automatic run_scan(input string tag, input int w, input int h, input int k, input int s,
                          input int exp_rc, input int exp_ec);
    int idx, rc, ec, last_acc, stall_left;
    bit got_done, stalling;
    img_w = 8'(w); img_h = 8'(h); ker = 4'(k); stride = 4'(s);
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq({tag, "_check_busy"}, busy, 1);
    check_eq({tag, "_check_valid"}, win_valid, 0);
    check_eq({tag, "_err_clr"}, error, 0);
    tick();
    check_eq({tag, "_first_valid"}, win_valid, 1);
    idx = 0; rc = 0; ec = 0; last_acc = -10; got_done = 0;
    stall_left = stall_len;
    for (int cyc = 0; cyc < 300 && !got_done; cyc++) begin
      stalling = 0;
      if (win_valid && int'(win_row) == stall_r && int'(win_col) == stall_c && stall_left > 0) begin
        ready = 1'b0; stall_left--; stalling = 1;
      end else begin
        ready = 1'b1;
      end
      start = (cyc == poke_cyc);
      if (win_valid && ready) begin
        if (idx < exp_r.size()) begin
          check_eq($sformatf("%s_row%0d", tag, idx), win_row, exp_r[idx]);
          check_eq($sformatf("%s_col%0d", tag, idx), win_col, exp_c[idx]);
        end
        idx++;
        last_acc = cyc;
      end
      tick();
      start = 1'b0;
      if (stalling) begin
        check_eq({tag, "_stall_valid"}, win_valid, 1);
        check_eq({tag, "_stall_pos"}, {win_row, win_col}, {8'(stall_r), 8'(stall_c)});
        check_eq({tag, "_stall_noclr"}, {eqst_clr, row_clr}, 0);
      end
      if (eqst_clr) ec++;
      if (row_clr) rc++;
      if (done) begin
        got_done = 1;
        check_eq({tag, "_done_lat"}, cyc, last_acc);
      end
    end
    check_eq({tag, "_done_seen"}, got_done, 1);
    check_eq({tag, "_nwin"}, idx, exp_r.size());
    check_eq({tag, "_row_clr_cnt"}, rc, exp_rc);
    check_eq({tag, "_eqst_clr_cnt"}, ec, exp_ec);
    check_eq({tag, "_valid_off"}, win_valid, 0);
`ifdef STRIDE_WINDOW_SEQUENCER_WINCOUNT_EN
    check_eq({tag, "_win_count"}, win_count, exp_r.size());
`endif
    tick();
    check_eq({tag, "_done_1cyc"}, done, 0);
    check_eq({tag, "_idle_busy"}, busy, 0);
    check_eq({tag, "_error"}, error, 0);
  endtask

  task automatic load_5x5_k3s1();
    exp_r = {0, 0, 0, 1, 1, 1, 2, 2, 2};
    exp_c = {0, 1, 2, 0, 1, 2, 0, 1, 2};
  endtask

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    tick(); tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();
    check_all_zero("post_reset");

    // Basic 5x5, K=3, S=1: 9 windows, 2 row clears, 8 column clears
    load_5x5_k3s1();
    run_scan("k3s1", 5, 5, 3, 1, 2, 8);

    // Stride 2 on 6x6
    exp_r = {0, 0, 2, 2};
    exp_c = {0, 2, 0, 2};
    run_scan("k3s2", 6, 6, 3, 2, 1, 3);

    // Backpressure on (0,1) for 3 cycles
    load_5x5_k3s1();
    stall_r = 0; stall_c = 1; stall_len = 3;
    run_scan("stall", 5, 5, 3, 1, 2, 8);
    stall_r = -1; stall_c = -1; stall_len = 0;

    // Illegal config: K > W
    img_w = 8'd5; img_h = 8'd5; ker = 4'd6; stride = 4'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("illegal_t1_busy", busy, 1);
    check_eq("illegal_t1_done", done, 0);
    check_eq("illegal_t1_valid", win_valid, 0);
    tick();
    check_eq("illegal_t2_done", done, 1);
    check_eq("illegal_t2_error", error, 1);
    check_eq("illegal_t2_valid", win_valid, 0);
    tick();
    check_eq("illegal_t3_done", done, 0);
    check_eq("illegal_t3_error_hold", error, 1);
    check_eq("illegal_t3_valid", win_valid, 0);
    tick();
    check_eq("illegal_t4_error_hold", error, 1);

    // Legal start clears the error; a second Start mid-scan is ignored
    load_5x5_k3s1();
    poke_cyc = 3;
    run_scan("restart_ign", 5, 5, 3, 1, 2, 8);
    poke_cyc = -1;

    // Reset in the middle of a scan at (1,1)
    img_w = 8'd5; img_h = 8'd5; ker = 4'd3; stride = 4'd1;
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (win_valid && win_row == 8'd1 && win_col == 8'd1) break;
      tick();
    end
    check_eq("midreset_reached", {win_valid, win_row, win_col}, {1'b1, 8'd1, 8'd1});
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midreset_async");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("midreset_no_done", {done, win_valid, busy}, 0);
    end
`ifdef STRIDE_WINDOW_SEQUENCER_WINCOUNT_EN
    check_eq("midreset_win_count", win_count, 0);
`endif
    load_5x5_k3s1();
    run_scan("after_reset", 5, 5, 3, 1, 2, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
